calc1_req_driver: RTL and testbench

CALC1_REQ_DRIVER -- requirements
Module: calc1_req_driver

---
 rtl/calc1_pkg.sv | 42 ++++
 rtl/calc1_req_driver_if.sv | 53 +++++
 rtl/calc1_wdog.sv | 41 ++++
 rtl/calc1_req_driver.sv | 147 ++++++++++++++
 tb/tb_calc1_req_driver.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/calc1_pkg.sv
// rtl/calc1_pkg.sv - shared command/response codes, FSM states and defaults for the calc1 request driver
//
// Purpose: single home for the constants every calc1 driver file agrees on.
// Contents:
//   DEFAULT_TIMEOUT  - default number of WAIT cycles before a local timeout
//   CMD_*            - calc1 command codes (only ADD/SUB/SHL/SHR are legal)
//   RESP_*           - response codes reported on res_resp
//   state_t          - driver FSM states
//   cmd_is_valid()   - legal-command test used at accept time
package calc1_pkg;

  localparam int DEFAULT_TIMEOUT = 16;

  localparam logic [3:0] CMD_NONE = 4'd0;
  localparam logic [3:0] CMD_ADD  = 4'd1;
  localparam logic [3:0] CMD_SUB  = 4'd2;
  localparam logic [3:0] CMD_SHL  = 4'd5;
  localparam logic [3:0] CMD_SHR  = 4'd6;

  localparam logic [1:0] RESP_NONE    = 2'd0;
  localparam logic [1:0] RESP_OK      = 2'd1;
  localparam logic [1:0] RESP_ERR     = 2'd2;
  localparam logic [1:0] RESP_TIMEOUT = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND1,
    ST_SEND2,
    ST_WAIT,
    ST_HOLD
  } state_t;

  function automatic logic cmd_is_valid(input logic [3:0] cmd);
    logic ok;
    case (cmd)
      CMD_ADD, CMD_SUB, CMD_SHL, CMD_SHR: ok = 1'b1;
      default:                            ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/calc1_req_driver_if.sv
// rtl/calc1_req_driver_if.sv - operation, calc1 port and result signals of the calc1 request driver
//
// Purpose: bundles the three handshakes the driver sits between.
// Signals:
//   op_valid/op_ready/op_cmd/op_data1/op_data2   - operation offered to the driver
//   calc_cmd_out/calc_data_out                   - request pins towards one calc1 port
//   calc_resp_in/calc_data_in                    - response pins from that calc1 port
//   res_valid/res_ready/res_resp/res_data        - result handshake
//   busy                                         - driver is not idle
// Modports:
//   slave  - the driver itself
//   master - the environment: issues ops, plays calc1, consumes results
interface calc1_req_driver_if;

  logic        op_valid;
  logic        op_ready;
  logic [3:0]  op_cmd;
  logic [31:0] op_data1;
  logic [31:0] op_data2;

  logic [3:0]  calc_cmd_out;
  logic [31:0] calc_data_out;
  logic [1:0]  calc_resp_in;
  logic [31:0] calc_data_in;

  logic        res_valid;
  logic        res_ready;
  logic [1:0]  res_resp;
  logic [31:0] res_data;

  logic        busy;

  modport slave (
    input  op_valid, op_cmd, op_data1, op_data2,
    input  calc_resp_in, calc_data_in,
    input  res_ready,
    output op_ready,
    output calc_cmd_out, calc_data_out,
    output res_valid, res_resp, res_data,
    output busy
  );

  modport master (
    output op_valid, op_cmd, op_data1, op_data2,
    output calc_resp_in, calc_data_in,
    output res_ready,
    input  op_ready,
    input  calc_cmd_out, calc_data_out,
    input  res_valid, res_resp, res_data,
    input  busy
  );

endinterface

// File: rtl/calc1_wdog.sv
// rtl/calc1_wdog.sv - WAIT-state cycle counter that flags a local timeout
//
// Purpose: counts enabled cycles; expired is high on the edge that completes
//          the TIMEOUT_CYCLES-th enabled cycle.
// Ports:
//   clk      in  clock
//   rst_n    in  asynchronous reset, active-low
//   clear    in  synchronous clear (wins over enable)
//   enable   in  count this cycle
//   expired  out this enabled cycle is the TIMEOUT_CYCLES-th one
module calc1_wdog
  import calc1_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] count;

  // count holds the number of already-completed enabled cycles, so the
  // current cycle is the last allowed one when count reaches TIMEOUT-1.
  assign expired = enable && (count == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/calc1_req_driver.sv
// rtl/calc1_req_driver.sv - drives one two-beat request into a calc1 port and returns its result
//
// Purpose: accepts an operation, sends cmd/op1 then 0/op2 on the calc1 pins,
//          waits for a response or a local timeout and holds the result until
//          it is taken. Illegal commands are answered locally with RESP_ERR.
// Ports:
//   c_clk   in  clock, all state changes on the rising edge
//   reset   in  asynchronous reset, active-low
//   bus     slave modport of calc1_req_driver_if (op, calc1 and result signals)
// Parameters:
//   TIMEOUT_CYCLES  maximum number of WAIT cycles before RESP_TIMEOUT
module calc1_req_driver
  import calc1_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic              c_clk,
  input  logic              reset,
  calc1_req_driver_if.slave bus
);

  state_t      state, state_n;

  logic [31:0] op2_q, op2_n;
  logic [3:0]  calc_cmd_q, calc_cmd_n;
  logic [31:0] calc_data_q, calc_data_n;
  logic        res_valid_q, res_valid_n;
  logic [1:0]  res_resp_q, res_resp_n;
  logic [31:0] res_data_q, res_data_n;

  logic        wd_clear;
  logic        wd_enable;
  logic        wd_expired;

  calc1_wdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .clk    (c_clk),
    .rst_n  (reset),
    .clear  (wd_clear),
    .enable (wd_enable),
    .expired(wd_expired)
  );

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Every pin value is computed for the state being entered and registered,
  // so the pins change together with the state.
  always_comb begin
    state_n     = state;
    op2_n       = op2_q;
    calc_cmd_n  = CMD_NONE;
    calc_data_n = '0;
    res_valid_n = 1'b0;
    res_resp_n  = RESP_NONE;
    res_data_n  = '0;
    wd_enable   = (state == ST_WAIT);
    wd_clear    = (state != ST_WAIT);

    case (state)
      ST_IDLE: begin
        if (bus.op_valid) begin
          if (cmd_is_valid(bus.op_cmd)) begin
            state_n     = ST_SEND1;
            calc_cmd_n  = bus.op_cmd;
            calc_data_n = bus.op_data1;
            op2_n       = bus.op_data2;
          end else begin
            state_n     = ST_HOLD;
            res_valid_n = 1'b1;
            res_resp_n  = RESP_ERR;
          end
        end
      end

      ST_SEND1: begin
        state_n     = ST_SEND2;
        calc_data_n = op2_q;
      end

      ST_SEND2: begin
        state_n = ST_WAIT;
      end

      ST_WAIT: begin
        // A response on the timeout edge still wins.
        if (bus.calc_resp_in != RESP_NONE) begin
          state_n     = ST_HOLD;
          res_valid_n = 1'b1;
          res_resp_n  = bus.calc_resp_in;
          res_data_n  = bus.calc_data_in;
        end else if (wd_expired) begin
          state_n     = ST_HOLD;
          res_valid_n = 1'b1;
          res_resp_n  = RESP_TIMEOUT;
        end
      end

      ST_HOLD: begin
        if (bus.res_ready) begin
          state_n = ST_IDLE;
        end else begin
          res_valid_n = 1'b1;
          res_resp_n  = res_resp_q;
          res_data_n  = res_data_q;
        end
      end

      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      op2_q       <= '0;
      calc_cmd_q  <= CMD_NONE;
      calc_data_q <= '0;
      res_valid_q <= 1'b0;
      res_resp_q  <= RESP_NONE;
      res_data_q  <= '0;
    end else begin
      op2_q       <= op2_n;
      calc_cmd_q  <= calc_cmd_n;
      calc_data_q <= calc_data_n;
      res_valid_q <= res_valid_n;
      res_resp_q  <= res_resp_n;
      res_data_q  <= res_data_n;
    end
  end

  assign bus.op_ready      = (state == ST_IDLE);
  assign bus.busy          = (state != ST_IDLE);
  assign bus.calc_cmd_out  = calc_cmd_q;
  assign bus.calc_data_out = calc_data_q;
  assign bus.res_valid     = res_valid_q;
  assign bus.res_resp      = res_resp_q;
  assign bus.res_data      = res_data_q;

endmodule

// File: tb/tb_calc1_req_driver.sv
// tb/tb_calc1_req_driver.sv - self-checking bench for calc1_req_driver
module tb_calc1_req_driver;

  localparam int TMO = 16;

  logic c_clk = 1'b0;
  logic reset = 1'b0;

  calc1_req_driver_if bus ();

  calc1_req_driver #(
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .c_clk(c_clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 c_clk = ~c_clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // calc1 behaviour: {resp, data}
  function automatic logic [33:0] calc_fn(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    case (c)
      4'd1: begin s = {1'b0, a} + {1'b0, b}; return {(s[32] ? 2'd2 : 2'd1), s[31:0]}; end
      4'd2: return {((b > a) ? 2'd2 : 2'd1), a - b};
      4'd5: return {2'd1, a << b[4:0]};
      4'd6: return {2'd1, a >> b[4:0]};
      default: return {2'd2, 32'd0};
    endcase
  endfunction

  // Transaction model: k counts cycles since the accept edge (cycle 1 is the
  // first cycle after it); the result is due from cycle m_res_at onwards.
  bit          m_busy = 0;
  int          k = 0;
  int          m_res_at = 0;
  bit          m_vcmd = 0;
  logic [3:0]  m_cmd = 0;
  logic [31:0] m_d1 = 0, m_d2 = 0;
  logic [1:0]  m_resp = 0;
  logic [31:0] m_data = 0;
  int          m_dly = 0;
  int          cur_dly = 0;
  int          acc_count = 0;
  int          cyc = 0, acc_cyc = 0, done_cyc = 0;

  // observations for the literal checks
  int          first_rv_k = -1;
  logic [1:0]  obs_resp = 0;
  logic [31:0] obs_data = 0;
  logic [3:0]  obs_c1 = 0, obs_c2 = 0;
  logic [31:0] obs_d1 = 0, obs_d2 = 0;
  int          cmd_nz = 0;
  int          rv_seen = 0;

  always @(posedge c_clk) begin
    logic [33:0] r;
    logic        e_rv;
    cyc++;
    if (!reset) begin
      m_busy = 0;
      k = 0;
    end else if (!m_busy) begin
      if (bus.op_valid) begin
        m_busy = 1; k = 1;
        m_cmd = bus.op_cmd; m_d1 = bus.op_data1; m_d2 = bus.op_data2;
        m_dly = cur_dly;
        m_vcmd = (m_cmd == 4'd1) || (m_cmd == 4'd2) || (m_cmd == 4'd5) || (m_cmd == 4'd6);
        acc_count++; acc_cyc = cyc;
        first_rv_k = -1; cmd_nz = 0;
        if (!m_vcmd) begin
          m_res_at = 1; m_resp = 2'd2; m_data = 0;
        end else if (m_dly < 1 || m_dly > TMO) begin
          m_res_at = 3 + TMO; m_resp = 2'd3; m_data = 0;
        end else begin
          m_res_at = 3 + m_dly;
          r = calc_fn(m_cmd, m_d1, m_d2);
          m_resp = r[33:32]; m_data = r[31:0];
        end
      end
    end else if (k >= m_res_at && bus.res_ready) begin
      m_busy = 0; done_cyc = cyc;
    end else begin
      k++;
    end

    #1;
    e_rv = m_busy && (k >= m_res_at);
    chk("op_ready", bus.op_ready, !m_busy);
    chk("busy", bus.busy, m_busy);
    chk("calc_cmd_out", bus.calc_cmd_out, (m_busy && m_vcmd && k == 1) ? m_cmd : 4'd0);
    chk("calc_data_out", bus.calc_data_out,
        (m_busy && m_vcmd && k == 1) ? m_d1 : (m_busy && m_vcmd && k == 2) ? m_d2 : 32'd0);
    chk("res_valid", bus.res_valid, e_rv);
    if (e_rv) begin
      chk("res_resp", bus.res_resp, m_resp);
      chk("res_data", bus.res_data, m_data);
    end

    if (bus.res_valid) rv_seen++;
    if (m_busy) begin
      if (bus.calc_cmd_out != 4'd0) cmd_nz++;
      if (k == 1) begin obs_c1 = bus.calc_cmd_out; obs_d1 = bus.calc_data_out; end
      if (k == 2) begin obs_c2 = bus.calc_cmd_out; obs_d2 = bus.calc_data_out; end
      if (bus.res_valid && first_rv_k < 0) begin
        first_rv_k = k; obs_resp = bus.res_resp; obs_data = bus.res_data;
      end
    end
  end

  // calc1 port model: answers in WAIT cycle m_dly, is quiet in the other WAIT
  // cycles, and drives junk whenever the driver must be ignoring it.
  always @(negedge c_clk) begin
    logic [33:0] r;
    if (m_busy && m_vcmd && m_dly > 0 && k == 2 + m_dly) begin
      r = calc_fn(m_cmd, m_d1, m_d2);
      bus.calc_resp_in = r[33:32];
      bus.calc_data_in = r[31:0];
    end else if (m_busy && m_vcmd && k >= 3 && k < m_res_at) begin
      bus.calc_resp_in = 2'd0;
      bus.calc_data_in = 32'd0;
    end else begin
      bus.calc_resp_in = 2'd3;
      bus.calc_data_in = 32'hDEADBEEF;
    end
  end

  task automatic start_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b, input int dly);
    int n, t;
    @(negedge c_clk);
    bus.op_valid = 1'b1; bus.op_cmd = c; bus.op_data1 = a; bus.op_data2 = b;
    cur_dly = dly;
    n = acc_count;
    t = 0;
    while (acc_count == n && t < 50) begin @(negedge c_clk); t++; end
    if (t >= 50) chk("accept_timeout", 1, 0);
    bus.op_valid = 1'b0;
  endtask

  task automatic wait_result();
    int t = 0;
    while (!(m_busy && k >= m_res_at) && t < 40) begin @(negedge c_clk); t++; end
    if (t >= 40) chk("result_timeout", 1, 0);
  endtask

  task automatic finish_op(input int hold);
    repeat (hold) @(negedge c_clk);
    bus.res_ready = 1'b1;
    @(negedge c_clk);
    bus.res_ready = 1'b0;
  endtask

  task automatic run_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b, input int dly);
    start_op(c, a, b, dly);
    wait_result();
    finish_op(0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.op_valid = 0; bus.op_cmd = 0; bus.op_data1 = 0; bus.op_data2 = 0;
    bus.res_ready = 0;
    repeat (3) @(negedge c_clk);
    chk("rst_calc_cmd", bus.calc_cmd_out, 0);
    chk("rst_calc_data", bus.calc_data_out, 0);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_res_resp", bus.res_resp, 0);
    chk("rst_res_data", bus.res_data, 0);
    reset = 1'b1;
    @(posedge c_clk); #1;
    chk("rst_op_ready_first_edge", bus.op_ready, 1);

    // add with result one cycle after two WAIT cycles
    run_op(4'd1, 32'h00000001, 32'h01FFFFFF, 2);
    chk("add_c1", obs_c1, 4'd1);
    chk("add_d1", obs_d1, 32'h00000001);
    chk("add_c2", obs_c2, 4'd0);
    chk("add_d2", obs_d2, 32'h01FFFFFF);
    chk("add_resp", obs_resp, 2'd1);
    chk("add_data", obs_data, 32'h02000000);
    chk("add_latency", first_rv_k, 5);

    // illegal command answered locally
    run_op(4'd3, 32'h12345678, 32'h9ABCDEF0, 1);
    chk("inv_latency", first_rv_k, 1);
    chk("inv_resp", obs_resp, 2'd2);
    chk("inv_data", obs_data, 0);
    chk("inv_calc_quiet", cmd_nz, 0);

    run_op(4'd0, 32'h1, 32'h1, 1);
    chk("cmd0_resp", obs_resp, 2'd2);

    // calc1 never answers
    run_op(4'd2, 32'd9, 32'd4, 0);
    chk("tmo_latency", first_rv_k, 3 + 16);
    chk("tmo_resp", obs_resp, 2'd3);
    chk("tmo_data", obs_data, 0);
    @(negedge c_clk);
    chk("tmo_busy_clear", bus.busy, 0);

    // overflow reported by calc1
    run_op(4'd1, 32'hFFFFFFFF, 32'h00000001, 1);
    chk("ovf_latency", first_rv_k, 4);
    chk("ovf_resp", obs_resp, 2'd2);
    chk("ovf_data", obs_data, 32'h00000000);

    // response on the same edge as the timeout wins
    run_op(4'd2, 32'd10, 32'd3, 16);
    chk("prio_latency", first_rv_k, 19);
    chk("prio_resp", obs_resp, 2'd1);
    chk("prio_data", obs_data, 32'd7);

    run_op(4'd5, 32'h1, 32'd4, 15);
    chk("shl_data", obs_data, 32'h10);
    chk("shl_latency", first_rv_k, 18);
    run_op(4'd6, 32'h80000000, 32'd31, 1);
    chk("shr_data", obs_data, 32'h1);

    // result held while res_ready stays low; next op goes in right after
    start_op(4'd2, 32'd100, 32'd1, 3);
    wait_result();
    repeat (5) @(negedge c_clk);
    chk("hold_valid", bus.res_valid, 1);
    chk("hold_resp", bus.res_resp, 2'd1);
    chk("hold_data", bus.res_data, 32'd99);
    chk("hold_op_ready", bus.op_ready, 0);
    bus.op_valid = 1'b1; bus.op_cmd = 4'd1; bus.op_data1 = 32'd5; bus.op_data2 = 32'd6;
    cur_dly = 1;
    bus.res_ready = 1'b1;
    @(negedge c_clk);
    bus.res_ready = 1'b0;
    begin
      int t = 0;
      while (!(m_busy && acc_cyc > done_cyc) && t < 10) begin @(negedge c_clk); t++; end
    end
    bus.op_valid = 1'b0;
    chk("reaccept_gap", acc_cyc - done_cyc, 1);
    wait_result();
    finish_op(0);
    chk("reaccept_data", obs_data, 32'd11);

    // reset in the middle of WAIT abandons the operation
    start_op(4'd1, 32'd1, 32'd2, 0);
    begin
      int t = 0;
      while (k < 5 && t < 20) begin @(negedge c_clk); t++; end
    end
    reset = 1'b0;
    repeat (2) @(negedge c_clk);
    rv_seen = 0;
    reset = 1'b1;
    @(posedge c_clk); #1;
    chk("rst_mid_op_ready", bus.op_ready, 1);
    repeat (25) @(negedge c_clk);
    chk("rst_mid_no_result", rv_seen, 0);

    run_op(4'd1, 32'd2, 32'd3, 4);
    chk("post_rst_data", obs_data, 32'd5);

    repeat (3) @(negedge c_clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
